// File: rtl/ysyx_22040931_assoc_table_pkg.sv
//==============================================================================
// Module   : ysyx_22040931_assoc_table_pkg
// Brief    : Shared types and sizing helpers for the associative key/data table.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package ysyx_22040931_assoc_table_pkg;

    // Entry index width; a single-entry table still needs one bit of pointer.
    function automatic int idx_w(input int nr);
        return (nr > 1) ? $clog2(nr) : 1;
    endfunction

    typedef enum logic [1:0] {
        WR_NONE   = 2'd0,
        WR_UPDATE = 2'd1,
        WR_INSERT = 2'd2,
        WR_EVICT  = 2'd3
    } wr_kind_e;

endpackage

`default_nettype wire

// File: rtl/ysyx_22040931_assoc_match.sv
//==============================================================================
// Module   : ysyx_22040931_assoc_match
// Brief    : Combinational key compare over the table: one-hot match, hit,
//            lowest free entry and full flag.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ysyx_22040931_assoc_match
    import ysyx_22040931_assoc_table_pkg::*;
#(
    parameter  int NR_KEY  = 4,
    parameter  int KEY_LEN = 8,
    localparam int IDX_W   = idx_w(NR_KEY)
) (
    input  logic [KEY_LEN-1:0]        key,
    input  logic [NR_KEY*KEY_LEN-1:0] keys,
    input  logic [NR_KEY-1:0]         valid,
    output logic [NR_KEY-1:0]         match_oh,
    output logic                      hit,
    output logic [IDX_W-1:0]          free_idx,
    output logic                      full
);

    genvar gi;
    generate
        for (gi = 0; gi < NR_KEY; gi++) begin : g_match
            assign match_oh[gi] = valid[gi] && (keys[gi*KEY_LEN +: KEY_LEN] == key);
        end
    endgenerate

    assign hit  = |match_oh;
    assign full = &valid;

    // Scan downward so the lowest invalid index wins.
    always_comb begin
        free_idx = '0;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (!valid[i]) free_idx = IDX_W'(i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_22040931_assoc_table.sv
//==============================================================================
// Module   : ysyx_22040931_assoc_table
// Brief    : Run-time writable key->data table with valid/ready lookup and a
//            one-cycle registered response. Optional lookup statistics are
//            built when YSYX_22040931_ASSOC_STATS_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ysyx_22040931_assoc_table
    import ysyx_22040931_assoc_table_pkg::*;
#(
    parameter int NR_KEY      = 4,
    parameter int KEY_LEN     = 8,
    parameter int DATA_LEN    = 32,
    parameter bit HAS_DEFAULT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lk_valid,
    output logic                lk_ready,
    input  logic [KEY_LEN-1:0]  lk_key,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_hit,
    output logic [DATA_LEN-1:0] rsp_data,
    input  logic [DATA_LEN-1:0] default_out,
    input  logic                wr_en,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
`ifdef YSYX_22040931_ASSOC_STATS_EN
    output logic [31:0]         stat_hit,
    output logic [31:0]         stat_miss,
`endif
    input  logic                flush
);

    localparam int PAIR_LEN = KEY_LEN + DATA_LEN;
    localparam int IDX_W    = idx_w(NR_KEY);

    // Each entry packs {key, data}.
    logic [PAIR_LEN-1:0]       entry_q [NR_KEY];
    logic [PAIR_LEN-1:0]       entry_d [NR_KEY];
    logic [NR_KEY-1:0]         valid_q, valid_d;
    logic [IDX_W-1:0]          victim_q, victim_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic                      rsp_hit_q, rsp_hit_d;
    logic [DATA_LEN-1:0]       rsp_data_q, rsp_data_d;

    logic [NR_KEY*KEY_LEN-1:0] keys_flat;
    logic [NR_KEY-1:0]         lk_match, wr_match;
    logic                      lk_hit, wr_hit, lk_full, wr_full;
    logic [IDX_W-1:0]          lk_free, wr_free;
    logic [DATA_LEN-1:0]       lk_data;
    logic                      lk_accept;
    wr_kind_e                  wr_kind;

    genvar gi;
    generate
        for (gi = 0; gi < NR_KEY; gi++) begin : g_keys
            assign keys_flat[gi*KEY_LEN +: KEY_LEN] = entry_q[gi][PAIR_LEN-1 -: KEY_LEN];
        end
    endgenerate

    ysyx_22040931_assoc_match #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN)) u_lk_match (
        .key      (lk_key),
        .keys     (keys_flat),
        .valid    (valid_q),
        .match_oh (lk_match),
        .hit      (lk_hit),
        .free_idx (lk_free),
        .full     (lk_full)
    );

    ysyx_22040931_assoc_match #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN)) u_wr_match (
        .key      (wr_key),
        .keys     (keys_flat),
        .valid    (valid_q),
        .match_oh (wr_match),
        .hit      (wr_hit),
        .free_idx (wr_free),
        .full     (wr_full)
    );

    // Free/full outputs of the lookup instance have no consumer.
    logic unused_lk;
    assign unused_lk = ^{lk_free, lk_full};

    assign lk_ready  = !rsp_valid_q || rsp_ready;
    assign lk_accept = lk_valid && lk_ready;

    always_comb begin
        lk_data = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (lk_match[i]) lk_data = lk_data | entry_q[i][DATA_LEN-1:0];
        end
    end

    always_comb begin
        wr_kind = WR_NONE;
        if (wr_en && !flush) begin
            if (wr_hit)        wr_kind = WR_UPDATE;
            else if (!wr_full) wr_kind = WR_INSERT;
            else               wr_kind = WR_EVICT;
        end
    end

    always_comb begin
        entry_d  = entry_q;
        valid_d  = valid_q;
        victim_d = victim_q;
        if (flush) begin
            valid_d  = '0;
            victim_d = '0;
        end
        case (wr_kind)
            WR_UPDATE: begin
                for (int i = 0; i < NR_KEY; i++) begin
                    if (wr_match[i]) entry_d[i][DATA_LEN-1:0] = wr_data;
                end
            end
            WR_INSERT: begin
                valid_d[wr_free] = 1'b1;
                entry_d[wr_free] = {wr_key, wr_data};
            end
            WR_EVICT: begin
                entry_d[victim_q] = {wr_key, wr_data};
                victim_d = (victim_q == IDX_W'(NR_KEY - 1)) ? '0 : victim_q + IDX_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_data_d  = rsp_data_q;
        if (lk_accept) begin
            rsp_valid_d = 1'b1;
            rsp_hit_d   = lk_hit;
            rsp_data_d  = lk_hit ? lk_data : (HAS_DEFAULT ? default_out : '0);
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            victim_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            victim_q    <= victim_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Key/data storage is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_data  = rsp_data_q;

`ifdef YSYX_22040931_ASSOC_STATS_EN
    logic [31:0] stat_hit_q, stat_hit_d;
    logic [31:0] stat_miss_q, stat_miss_d;

    always_comb begin
        stat_hit_d  = stat_hit_q;
        stat_miss_d = stat_miss_q;
        if (lk_accept) begin
            if (lk_hit) stat_hit_d  = stat_hit_q + 32'd1;
            else        stat_miss_d = stat_miss_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hit_q  <= '0;
            stat_miss_q <= '0;
        end else begin
            stat_hit_q  <= stat_hit_d;
            stat_miss_q <= stat_miss_d;
        end
    end

    assign stat_hit  = stat_hit_q;
    assign stat_miss = stat_miss_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040931_assoc_table.sv
//==============================================================================
// Module   : tb_ysyx_22040931_assoc_table
// Brief    : Self-checking bench for ysyx_22040931_assoc_table: directed
//            scenarios followed by random traffic against a reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ysyx_22040931_assoc_table;

    localparam int NR_KEY   = 4;
    localparam int KEY_LEN  = 8;
    localparam int DATA_LEN = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                lk_valid;
    logic                lk_ready;
    logic [KEY_LEN-1:0]  lk_key;
    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_hit;
    logic [DATA_LEN-1:0] rsp_data;
    logic [DATA_LEN-1:0] default_out;
    logic                wr_en;
    logic [KEY_LEN-1:0]  wr_key;
    logic [DATA_LEN-1:0] wr_data;
    logic                flush;
`ifdef YSYX_22040931_ASSOC_STATS_EN
    logic [31:0]         stat_hit, stat_miss;
`endif

    always #5 clk = ~clk;

    ysyx_22040931_assoc_table #(
        .NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN), .HAS_DEFAULT(1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lk_valid    (lk_valid),
        .lk_ready    (lk_ready),
        .lk_key      (lk_key),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_hit     (rsp_hit),
        .rsp_data    (rsp_data),
        .default_out (default_out),
        .wr_en       (wr_en),
        .wr_key      (wr_key),
        .wr_data     (wr_data),
`ifdef YSYX_22040931_ASSOC_STATS_EN
        .stat_hit    (stat_hit),
        .stat_miss   (stat_miss),
`endif
        .flush       (flush)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the table is a list of (key, data) slots plus the
    // replacement pointer; the response is what a consumer should see.
    bit          m_used [NR_KEY];
    int          m_key  [NR_KEY];
    logic [31:0] m_data [NR_KEY];
    int          m_vic;
    bit          m_rv;
    bit          m_hit;
    logic [31:0] m_rdata;
    int          m_shit, m_smiss;

    function automatic int model_find(input int key);
        for (int i = 0; i < NR_KEY; i++)
            if (m_used[i] && m_key[i] == key) return i;
        return -1;
    endfunction

    task automatic model_clock();
        int  idx;
        bit  accept;
        if (rst) begin
            for (int i = 0; i < NR_KEY; i++) m_used[i] = 0;
            m_vic = 0; m_rv = 0; m_hit = 0; m_rdata = '0;
            m_shit = 0; m_smiss = 0;
            return;
        end
        accept = lk_valid && (!m_rv || rsp_ready);
        // Lookup sees the table as it was before this cycle's write/flush.
        if (accept) begin
            idx = model_find(int'(lk_key));
            m_rv = 1;
            if (idx >= 0) begin m_hit = 1; m_rdata = m_data[idx]; m_shit++;  end
            else          begin m_hit = 0; m_rdata = default_out; m_smiss++; end
        end else if (rsp_ready) begin
            m_rv = 0;
        end
        if (flush) begin
            for (int i = 0; i < NR_KEY; i++) m_used[i] = 0;
            m_vic = 0;
        end else if (wr_en) begin
            idx = model_find(int'(wr_key));
            if (idx < 0) begin
                for (int i = 0; i < NR_KEY && idx < 0; i++) if (!m_used[i]) idx = i;
            end
            if (idx < 0) begin
                idx   = m_vic;
                m_vic = (m_vic + 1) % NR_KEY;
            end
            m_used[idx] = 1;
            m_key[idx]  = int'(wr_key);
            m_data[idx] = wr_data;
        end
    endtask

    task automatic step();
        #1;
        chk("lk_ready", lk_ready, !m_rv || rsp_ready);
        @(posedge clk);
        model_clock();
        @(negedge clk);
        chk("rsp_valid", rsp_valid, m_rv);
        chk("rsp_hit",   rsp_hit,   m_hit);
        chk("rsp_data",  rsp_data,  m_rdata);
`ifdef YSYX_22040931_ASSOC_STATS_EN
        chk("stat_hit",  stat_hit,  m_shit);
        chk("stat_miss", stat_miss, m_smiss);
`endif
    endtask

    task automatic idle();
        rst = 0; lk_valid = 0; lk_key = '0; rsp_ready = 1; default_out = 32'hDEAD;
        wr_en = 0; wr_key = '0; wr_data = '0; flush = 0;
    endtask

    task automatic wr(input int k, input logic [31:0] d);
        idle(); wr_en = 1; wr_key = KEY_LEN'(k); wr_data = d; step();
    endtask

    task automatic lk(input int k);
        idle(); lk_valid = 1; lk_key = KEY_LEN'(k); step();
    endtask

    logic [31:0] held;

    initial begin
        idle();
        rst = 1;
        step(); step();
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_data",  rsp_data,  32'h0);

        lk(8'h12);
        chk("plan_miss_default", {rsp_valid, rsp_hit, rsp_data}, {2'b10, 32'hDEAD});
        wr(8'h12, 32'hA5A5A5A5);
        lk(8'h12);
        chk("plan_hit_data", {rsp_hit, rsp_data}, {1'b1, 32'hA5A5A5A5});
        wr(8'h12, 32'h1);
        lk(8'h12);
        chk("plan_update", rsp_data, 32'h1);

        // Fill then evict twice; the 0x12 slot is the first victim.
        idle(); flush = 1; step();
        for (int k = 1; k <= 6; k++) wr(k, 32'h100 + k);
        for (int k = 1; k <= 6; k++) begin
            lk(k);
            chk($sformatf("plan_evict_k%0d", k), rsp_hit, (k >= 3));
        end

        // Backpressure: response must hold while consumer stalls.
        idle(); lk_valid = 1; lk_key = 8'd3; rsp_ready = 0; step();
        held = rsp_data;
        for (int c = 0; c < 3; c++) begin
            lk_key = 8'd4; step();
            chk("stall_ready", lk_ready, 1'b0);
            chk("stall_hold",  rsp_data, held);
        end
        rsp_ready = 1; step();
        chk("release_data", rsp_data, 32'h104);

        // flush wins over a simultaneous write.
        idle(); flush = 1; wr_en = 1; wr_key = 8'd7; wr_data = 32'h77; step();
        lk(7);
        chk("flush_drops_write", rsp_hit, 1'b0);
        for (int k = 10; k <= 14; k++) wr(k, 32'h200 + k);
        lk(10);
        chk("victim_reset_evicts_slot0", rsp_hit, 1'b0);

        // Same-cycle lookup and write of one key returns the old value.
        idle(); lk_valid = 1; lk_key = 8'd11; wr_en = 1; wr_key = 8'd11; wr_data = 32'hBEEF; step();
        chk("no_bypass", rsp_data, 32'h20B);
        lk(11);
        chk("write_visible", rsp_data, 32'hBEEF);

        // Random traffic over a small key space to exercise hits and eviction.
        for (int c = 0; c < 1500; c++) begin
            rst         = ($urandom_range(0, 199) == 0);
            lk_valid    = ($urandom_range(0, 9) < 7);
            lk_key      = KEY_LEN'($urandom_range(0, 7));
            rsp_ready   = ($urandom_range(0, 9) < 7);
            default_out = $urandom;
            wr_en       = ($urandom_range(0, 9) < 4);
            wr_key      = KEY_LEN'($urandom_range(0, 7));
            wr_data     = $urandom;
            flush       = ($urandom_range(0, 49) == 0);
            step();
        end

        idle(); rst = 1; step();
        chk("final_reset_valid", rsp_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
